// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state, opcode and select encodings for the CPU control FSM
package cpu_pkg;

  typedef enum logic [4:0] {
    S_RST,
    S_IF1,
    S_IF2,
    S_UPDATE_PC,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WB,
    S_WR_IMM,
    S_ADDR,
    S_LD_ADDR,
    S_MEM_RD,
    S_LDR_WB,
    S_STR_RD,
    S_STR_C,
    S_MEM_WR,
    S_BRANCH,
    S_HALT
  } state_t;

  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_ALU  = 3'b101;
  localparam logic [2:0] OP_LDR  = 3'b011;
  localparam logic [2:0] OP_STR  = 3'b100;
  localparam logic [2:0] OP_B    = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  // ALU_op meaning under OP_ALU, and the two MOV flavours under OP_MOV
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;
  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;

  localparam logic [1:0] REG_SEL_RM = 2'b00;
  localparam logic [1:0] REG_SEL_RD = 2'b01;
  localparam logic [1:0] REG_SEL_RN = 2'b10;

  localparam logic [1:0] WB_SEL_C     = 2'b00;
  localparam logic [1:0] WB_SEL_IMM   = 2'b10;
  localparam logic [1:0] WB_SEL_MDATA = 2'b11;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - branch condition evaluation from the status flags
module branch_cond (
  input  logic [2:0] cond,
  input  logic       Z,
  input  logic       N,
  input  logic       V,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      3'b000:  taken = 1'b1;
      3'b001:  taken = Z;
      3'b010:  taken = ~Z;
      3'b011:  taken = N ^ V;
      3'b100:  taken = Z | (N ^ V);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - Moore control FSM sequencing fetch, decode, execute, memory and writeback
module cpu_controller
  import cpu_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic [1:0] ALU_op,
  input  logic [2:0] cond,
  input  logic       Z,
  input  logic       N,
  input  logic       V,
  output logic [1:0] reg_sel,
  output logic [1:0] wb_sel,
  output logic       write,
  output logic       load_a,
  output logic       load_b,
  output logic       load_c,
  output logic       load_s,
  output logic       asel,
  output logic       bsel,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       pc_sel,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic       halted
);

  state_t state_q, state_d;
  logic   taken;
  logic   is_cmp;
  logic   is_mvn;
  state_t illegal_next;

  branch_cond u_branch_cond (
    .cond  (cond),
    .Z     (Z),
    .N     (N),
    .V     (V),
    .taken (taken)
  );

  assign is_cmp       = (opcode == OP_ALU) && (ALU_op == ALU_CMP);
  assign is_mvn       = (opcode == OP_ALU) && (ALU_op == ALU_MVN);
  assign illegal_next = HALT_ON_ILLEGAL ? S_HALT : S_IF1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RST;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    reg_sel   = REG_SEL_RM;
    wb_sel    = WB_SEL_C;
    write     = 1'b0;
    load_a    = 1'b0;
    load_b    = 1'b0;
    load_c    = 1'b0;
    load_s    = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    pc_sel    = 1'b0;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = MEM_NONE;
    halted    = 1'b0;

    case (state_q)
      S_RST: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
        state_d  = S_IF1;
      end
      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        state_d  = S_IF2;
      end
      S_IF2: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        load_ir  = 1'b1;
        state_d  = S_UPDATE_PC;
      end
      S_UPDATE_PC: begin
        load_pc = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_MOV: begin
            if (ALU_op == MOV_IMM)      state_d = S_WR_IMM;
            else if (ALU_op == MOV_REG) state_d = S_GET_B;
            else                        state_d = illegal_next;
          end
          // MVN is unary on Rm, so it skips the Rn read
          OP_ALU:         state_d = is_mvn ? S_GET_B : S_GET_A;
          OP_LDR, OP_STR: state_d = S_GET_A;
          OP_B:           state_d = S_BRANCH;
          OP_HALT:        state_d = S_HALT;
          default:        state_d = illegal_next;
        endcase
      end
      S_GET_A: begin
        reg_sel = REG_SEL_RN;
        load_a  = 1'b1;
        state_d = (opcode == OP_ALU) ? S_GET_B : S_ADDR;
      end
      S_GET_B: begin
        reg_sel = REG_SEL_RM;
        load_b  = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        load_c  = 1'b1;
        asel    = (opcode == OP_MOV) || is_mvn;
        load_s  = is_cmp;
        state_d = is_cmp ? S_IF1 : S_WB;
      end
      S_WB: begin
        reg_sel = REG_SEL_RD;
        wb_sel  = WB_SEL_C;
        write   = 1'b1;
        state_d = S_IF1;
      end
      S_WR_IMM: begin
        reg_sel = REG_SEL_RN;
        wb_sel  = WB_SEL_IMM;
        write   = 1'b1;
        state_d = S_IF1;
      end
      S_ADDR: begin
        bsel    = 1'b1;
        load_c  = 1'b1;
        state_d = S_LD_ADDR;
      end
      S_LD_ADDR: begin
        load_addr = 1'b1;
        state_d   = (opcode == OP_LDR) ? S_MEM_RD : S_STR_RD;
      end
      S_MEM_RD: begin
        mem_cmd = MEM_READ;
        state_d = S_LDR_WB;
      end
      S_LDR_WB: begin
        mem_cmd = MEM_READ;
        reg_sel = REG_SEL_RD;
        wb_sel  = WB_SEL_MDATA;
        write   = 1'b1;
        state_d = S_IF1;
      end
      S_STR_RD: begin
        reg_sel = REG_SEL_RD;
        load_b  = 1'b1;
        state_d = S_STR_C;
      end
      // C = 0 + B passes the store data through the ALU
      S_STR_C: begin
        asel    = 1'b1;
        load_c  = 1'b1;
        state_d = S_MEM_WR;
      end
      S_MEM_WR: begin
        mem_cmd = MEM_WRITE;
        state_d = S_IF1;
      end
      S_BRANCH: begin
        load_pc = taken;
        pc_sel  = taken;
        state_d = S_IF1;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_RST;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - randomized per-cycle check of cpu_controller against an instruction-level model
module tb_cpu_controller;

  typedef struct packed {
    logic [1:0] reg_sel;
    logic [1:0] wb_sel;
    logic       write;
    logic       load_a;
    logic       load_b;
    logic       load_c;
    logic       load_s;
    logic       asel;
    logic       bsel;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       pc_sel;
    logic       addr_sel;
    logic       load_addr;
    logic [1:0] mem_cmd;
    logic       halted;
  } out_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode = '0;
  logic [1:0] ALU_op = '0;
  logic [2:0] cond = '0;
  logic       Z = 1'b0, N = 1'b0, V = 1'b0;

  logic [1:0] reg_sel0, wb_sel0, mem_cmd0, reg_sel1, wb_sel1, mem_cmd1;
  logic write0, load_a0, load_b0, load_c0, load_s0, asel0, bsel0, load_ir0, load_pc0;
  logic reset_pc0, pc_sel0, addr_sel0, load_addr0, halted0;
  logic write1, load_a1, load_b1, load_c1, load_s1, asel1, bsel1, load_ir1, load_pc1;
  logic reset_pc1, pc_sel1, addr_sel1, load_addr1, halted1;
  out_t o0, o1;

  int checks = 0;
  int errors = 0;
  out_t exp_q[$];

  always #5 clk = ~clk;

  cpu_controller #(.HALT_ON_ILLEGAL(1'b0)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .ALU_op(ALU_op), .cond(cond),
    .Z(Z), .N(N), .V(V),
    .reg_sel(reg_sel0), .wb_sel(wb_sel0), .write(write0), .load_a(load_a0),
    .load_b(load_b0), .load_c(load_c0), .load_s(load_s0), .asel(asel0), .bsel(bsel0),
    .load_ir(load_ir0), .load_pc(load_pc0), .reset_pc(reset_pc0), .pc_sel(pc_sel0),
    .addr_sel(addr_sel0), .load_addr(load_addr0), .mem_cmd(mem_cmd0), .halted(halted0)
  );

  cpu_controller #(.HALT_ON_ILLEGAL(1'b1)) dut_hoi (
    .clk(clk), .rst(rst), .opcode(opcode), .ALU_op(ALU_op), .cond(cond),
    .Z(Z), .N(N), .V(V),
    .reg_sel(reg_sel1), .wb_sel(wb_sel1), .write(write1), .load_a(load_a1),
    .load_b(load_b1), .load_c(load_c1), .load_s(load_s1), .asel(asel1), .bsel(bsel1),
    .load_ir(load_ir1), .load_pc(load_pc1), .reset_pc(reset_pc1), .pc_sel(pc_sel1),
    .addr_sel(addr_sel1), .load_addr(load_addr1), .mem_cmd(mem_cmd1), .halted(halted1)
  );

  assign o0 = {reg_sel0, wb_sel0, write0, load_a0, load_b0, load_c0, load_s0, asel0, bsel0,
               load_ir0, load_pc0, reset_pc0, pc_sel0, addr_sel0, load_addr0, mem_cmd0, halted0};
  assign o1 = {reg_sel1, wb_sel1, write1, load_a1, load_b1, load_c1, load_s1, asel1, bsel1,
               load_ir1, load_pc1, reset_pc1, pc_sel1, addr_sel1, load_addr1, mem_cmd1, halted1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic out_t reset_word();
    out_t o = '0;
    o.reset_pc = 1'b1;
    o.load_pc  = 1'b1;
    return o;
  endfunction

  function automatic bit branch_taken(input logic [2:0] c, input logic z, input logic n, input logic v);
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return n != v;
      3'd4: return z || (n != v);
      default: return 1'b0;
    endcase
  endfunction

  // Expected output of every cycle of one instruction, IF1 first, from the instruction's meaning
  task automatic build_trace(input logic [2:0] op, input logic [1:0] alu, input logic [2:0] c,
                             input logic z, input logic n, input logic v);
    out_t o;
    bit mov_imm = (op == 3'b110) && (alu == 2'b10);
    bit unary   = ((op == 3'b110) && (alu == 2'b00)) || ((op == 3'b101) && (alu == 2'b11));
    bit binary  = (op == 3'b101) && (alu != 2'b11);
    bit cmp     = (op == 3'b101) && (alu == 2'b01);
    exp_q.delete();
    o = '0; o.addr_sel = 1; o.mem_cmd = 2'b01; exp_q.push_back(o);
    o.load_ir = 1; exp_q.push_back(o);
    o = '0; o.load_pc = 1; exp_q.push_back(o);
    o = '0; exp_q.push_back(o);
    if (mov_imm) begin
      o = '0; o.reg_sel = 2'b10; o.wb_sel = 2'b10; o.write = 1; exp_q.push_back(o);
    end else if (unary || binary) begin
      if (binary) begin o = '0; o.reg_sel = 2'b10; o.load_a = 1; exp_q.push_back(o); end
      o = '0; o.load_b = 1; exp_q.push_back(o);
      o = '0; o.load_c = 1; o.asel = unary; o.load_s = cmp; exp_q.push_back(o);
      if (!cmp) begin o = '0; o.reg_sel = 2'b01; o.write = 1; exp_q.push_back(o); end
    end else if (op == 3'b011 || op == 3'b100) begin
      o = '0; o.reg_sel = 2'b10; o.load_a = 1; exp_q.push_back(o);
      o = '0; o.bsel = 1; o.load_c = 1; exp_q.push_back(o);
      o = '0; o.load_addr = 1; exp_q.push_back(o);
      if (op == 3'b011) begin
        o = '0; o.mem_cmd = 2'b01; exp_q.push_back(o);
        o.reg_sel = 2'b01; o.wb_sel = 2'b11; o.write = 1; exp_q.push_back(o);
      end else begin
        o = '0; o.reg_sel = 2'b01; o.load_b = 1; exp_q.push_back(o);
        o = '0; o.asel = 1; o.load_c = 1; exp_q.push_back(o);
        o = '0; o.mem_cmd = 2'b10; exp_q.push_back(o);
      end
    end else if (op == 3'b001) begin
      o = '0;
      if (branch_taken(c, z, n, v)) begin o.load_pc = 1; o.pc_sel = 1; end
      exp_q.push_back(o);
    end else if (op == 3'b111) begin
      o = '0; o.halted = 1;
      for (int i = 0; i < 20; i++) exp_q.push_back(o);
    end
  endtask

  // Entered #1 after a rising edge; leaves #1 after the rising edge ending the last checked cycle
  task automatic run_instr(input string name, input logic [2:0] op, input logic [1:0] alu,
                           input logic [2:0] c, input logic z, input logic n, input logic v,
                           input int max_cycles);
    opcode = op; ALU_op = alu; cond = c; Z = z; N = n; V = v;
    build_trace(op, alu, c, z, n, v);
    for (int i = 0; i < exp_q.size() && i < max_cycles; i++) begin
      @(negedge clk);
      check($sformatf("%s cyc%0d", name, i), 32'(o0), 32'(exp_q[i]));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_async(input string name);
    #2 rst = 1'b1;
    #1 check({name, " async"}, 32'(o0), 32'(reset_word()));
    @(negedge clk);
    check({name, " held"}, 32'(o0), 32'(reset_word()));
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    #2 rst = 1'b1;
    #1 check("reset before clk", 32'(o0), 32'(reset_word()));
    check("reset before clk hoi", 32'(o1), 32'(reset_word()));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_instr("MOV imm", 3'b110, 2'b10, 3'd0, 0, 0, 0, 99);
    run_instr("CMP", 3'b101, 2'b01, 3'd0, 0, 0, 0, 99);
    run_instr("ADD", 3'b101, 2'b00, 3'd0, 0, 0, 0, 99);
    run_instr("MVN", 3'b101, 2'b11, 3'd0, 0, 0, 0, 99);
    run_instr("MOV reg", 3'b110, 2'b00, 3'd0, 0, 0, 0, 99);
    run_instr("LDR", 3'b011, 2'b00, 3'd0, 0, 0, 0, 99);
    run_instr("STR", 3'b100, 2'b00, 3'd0, 0, 0, 0, 99);
    run_instr("BLT", 3'b001, 2'b00, 3'd3, 0, 1, 0, 99);
    run_instr("BNE", 3'b001, 2'b00, 3'd2, 1, 0, 0, 99);
    run_instr("B c7", 3'b001, 2'b00, 3'd7, 1, 1, 0, 99);
    run_instr("ILL 000", 3'b000, 2'b00, 3'd0, 0, 0, 0, 99);
    run_instr("ILL 110/01", 3'b110, 2'b01, 3'd0, 0, 0, 0, 99);

    // abort a STR just before its memory write, and an ADD just before writeback
    run_instr("STR abort", 3'b100, 2'b00, 3'd0, 0, 0, 0, 9);
    reset_async("rst in STR");
    run_instr("ADD abort", 3'b101, 2'b00, 3'd0, 0, 0, 0, 7);
    reset_async("rst in ADD");

    for (int k = 0; k < 200; k++) begin
      logic [2:0] op  = 3'($urandom_range(0, 6));
      logic [1:0] alu = 2'($urandom);
      logic [2:0] c   = 3'($urandom);
      logic [2:0] f   = 3'($urandom);
      run_instr($sformatf("rnd%0d op%0b alu%0b c%0d f%0b", k, op, alu, c, f), op, alu, c, f[2], f[1], f[0], 99);
    end

    run_instr("HALT", 3'b111, 2'b00, 3'd0, 0, 0, 0, 99);
    reset_async("rst from HALT");
    run_instr("MOV after HALT", 3'b110, 2'b10, 3'd0, 0, 0, 0, 99);

    reset_async("rst before hoi");
    opcode = 3'b000; ALU_op = 2'b00;
    build_trace(3'b000, 2'b00, 3'd0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("hoi fetch cyc%0d", i), 32'(o1), 32'(exp_q[i]));
      @(posedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hoi halted %0d", i), 32'(halted1), 32'(1'b1));
      check($sformatf("nohoi not halted %0d", i), 32'(halted0), 32'(1'b0));
      @(posedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Control FSM directly downstream of the instruction decoder.
- Consumes the decoded opcode, ALU_op and cond fields, plus the datapath status flags Z/N/V.
- Sequences fetch, PC update, decode, register read, execute, memory access and writeback by driving the datapath and memory control strobes.
- Drives the decoder's reg_sel select, which chooses Rm/Rd/Rn for register file read/write addressing.

Parameters:
HALT_ON_ILLEGAL, 0, 1: an undefined opcode enters HALT; 0: it is treated as a NOP and returns to IF1.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  3  decoded ir[15:13]
ALU_op  in  2  decoded ir[12:11]
cond  in  3  decoded branch condition
Z  in  1  status zero flag
N  in  1  status negative flag
V  in  1  status overflow flag
reg_sel  out  2  to decoder: 00 Rm, 01 Rd, 10 Rn
wb_sel  out  2  writeback source: 00 C, 10 sximm8, 11 mdata
write  out  1  register file write enable
load_a  out  1  load A register
load_b  out  1  load B register
load_c  out  1  load C register
load_s  out  1  load status register
asel  out  1  1: ALU A input forced to 0
bsel  out  1  1: ALU B input = sximm5
load_ir  out  1  load instruction register
load_pc  out  1  load PC
reset_pc  out  1  PC next value = 0
pc_sel  out  1  PC next value: 0 = PC+1, 1 = PC+1+sximm8
addr_sel  out  1  memory address: 1 = PC, 0 = data address register
load_addr  out  1  load data address register from C
mem_cmd  out  2  00 NONE, 01 READ, 10 WRITE
halted  out  1  high while in HALT

Behaviour:
- Moore FSM with a single state register.
- Outputs decode from state, plus opcode/ALU_op where noted. The IR is stable from UPDATE_PC onward.
- Every output not listed for a state is 0 (mem_cmd = NONE).

Reset:
- rst=1 forces state RST asynchronously, independent of clk.
- Reset values: reset_pc=1, load_pc=1, all other outputs 0.
- Reset mid-instruction aborts it; no write or memory WRITE is issued after rst rises.

States, asserted outputs and transitions:
- RST: reset_pc, load_pc -> IF1.
- IF1: addr_sel=1, mem_cmd=READ -> IF2.
- IF2: addr_sel=1, mem_cmd=READ, load_ir -> UPDATE_PC.
- UPDATE_PC: load_pc, pc_sel=0 -> DECODE.
- DECODE: no outputs asserted. Dispatch:
  - 110/ALU_op 10 -> WR_IMM
  - 110/00 -> GET_B
  - 101/11 -> GET_B
  - 101/other -> GET_A
  - 011 -> GET_A
  - 100 -> GET_A
  - 001 -> BRANCH
  - 111 -> HALT
  - anything else -> IF1, or HALT if HALT_ON_ILLEGAL=1
- GET_A: reg_sel=10, load_a. Opcode 101 -> GET_B; opcode 011/100 -> ADDR.
- GET_B: reg_sel=00, load_b -> EXEC.
- EXEC: load_c.
  - asel=1 for opcode 110 and for 101/11.
  - load_s=1 only for 101/01 (CMP).
  - CMP -> IF1; otherwise -> WB.
- WB: reg_sel=01, wb_sel=00, write -> IF1.
- WR_IMM: reg_sel=10, wb_sel=10, write -> IF1.
- ADDR: bsel=1, load_c -> LD_ADDR.
- LD_ADDR: load_addr. Opcode 011 -> MEM_RD; opcode 100 -> STR_RD.
- MEM_RD: addr_sel=0, mem_cmd=READ -> LDR_WB.
- LDR_WB: addr_sel=0, mem_cmd=READ, reg_sel=01, wb_sel=11, write -> IF1.
- STR_RD: reg_sel=01, load_b -> STR_C.
- STR_C: asel=1, load_c -> MEM_WR.
- MEM_WR: addr_sel=0, mem_cmd=WRITE -> IF1.
- BRANCH: if taken, load_pc=1 and pc_sel=1; not taken asserts nothing. Either way -> IF1.
- HALT: halted=1; self-loop until rst.

Branch taken, by cond:
- 000: always taken
- 001: Z
- 010: !Z
- 011: N!=V
- 100: Z | (N!=V)
- 101-111: never taken

Invariants:
- write and mem_cmd=WRITE are never asserted in the same cycle.
- load_pc is asserted only in RST, UPDATE_PC and BRANCH.

Latency, counted from IF1 back to IF1:
- MOV imm: 5 cycles
- ALU: 8 cycles
- CMP: 7 cycles
- LDR: 9 cycles
- STR: 10 cycles
- B: 5 cycles

Decomposition:
- Shared package cpu_pkg holds:
  - state enum state_t
  - opcode constants: OP_MOV=110, OP_ALU=101, OP_LDR=011, OP_STR=100, OP_B=001, OP_HALT=111
  - ALU_op constants
  - REG_SEL_RM/RD/RN
  - WB_SEL_C/IMM/MDATA
  - MEM_NONE/READ/WRITE
- Sub-module branch_cond: combinational (cond, Z, N, V) -> taken.

Test Plan:
1. rst pulse mid-cycle -> same-cycle RST outputs (reset_pc=1, load_pc=1). After release: IF1, IF2 with load_ir, then UPDATE_PC.
2. MOV R1,#-5 (opcode 110, ALU_op 10) -> WR_IMM asserts reg_sel=10, wb_sel=10, write exactly once, 5 cycles after IF1.
3. CMP (101/01) -> load_s=1 in EXEC only, no write cycle. ADD (101/00) -> WB with reg_sel=01, write=1.
4. LDR then STR -> address/read/write sequence as specified:
   - LDR: ADDR bsel=1; MEM_RD/LDR_WB addr_sel=0, mem_cmd=READ; write in LDR_WB.
   - STR: STR_C asel=1; MEM_WR mem_cmd=WRITE, write=0.
5. BLT with N=1,V=0 -> load_pc=1, pc_sel=1. BNE with Z=1 -> no load_pc. cond=111 -> never taken.
6. Opcode 111 -> halted=1 held 20 cycles; rst recovers to RST. Opcode 000 with HALT_ON_ILLEGAL=0 -> IF1; with HALT_ON_ILLEGAL=1 -> HALT.
